// File: rtl/seq_div_24_pkg.sv
// Shared definitions for the sequential restoring divider: default width and FSM encoding.
package seq_div_24_pkg;

  localparam int unsigned DefWidth = 24;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/seq_div_24_div_step.sv
// One combinational restoring-division stage: shift in the next dividend bit, trial-subtract,
// keep the difference only when it does not go negative.
module seq_div_24_div_step #(
  parameter int unsigned WIDTH = 24
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_in, q_msb};
    diff    = shifted - {2'b00, div};
    // Top bit of the widened difference is the borrow: set means the divisor did not fit.
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_div_24.sv
// Sequential radix-2 restoring unsigned divider: q = a / b, r = a % b, one quotient bit per
// clock behind a start/done handshake, with a divide-by-zero shortcut.
module seq_div_24
  import seq_div_24_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;
  logic             accept;

  assign accept = (state_q == StIdle) && start;

  seq_div_24_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .q_msb   (quo_q[WIDTH-1]),
    .div     (div_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (b == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else if (accept) begin
      quo_q <= a;
      div_q <= b;
      rem_q <= '0;
      cnt_q <= CNT_W'(WIDTH - 1);
      if (b == '0) begin
        q   <= '1;
        r   <= a;
        dbz <= 1'b1;
      end else begin
        dbz <= 1'b0;
      end
    end else if (state_q == StRun) begin
      quo_q <= {quo_q[WIDTH-2:0], q_bit};
      rem_q <= rem_nxt;
      cnt_q <= cnt_q - CNT_W'(1);
      // Last iteration: publish the result so it is valid in the done cycle.
      if (cnt_q == '0) begin
        q <= {quo_q[WIDTH-2:0], q_bit};
        r <= rem_nxt[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_div_24.sv
// Directed and random checks of seq_div_24: latency, handshake, divide-by-zero and reset abort.
module tb_seq_div_24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] a, b, q, r;
  logic        busy, done, dbz;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_div_24 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dbz   (dbz)
  );

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle; returns in the done cycle (or after the bound expires).
  task automatic run_op(input logic [23:0] av, input logic [23:0] bv,
                        output int lat, output int busy_n);
    a     = av;
    b     = bv;
    start = 1'b1;
    step();
    start  = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      step();
      lat++;
    end
    check_eq("done_seen", {47'b0, done}, 48'd1);
  endtask

  logic [23:0] ext_a [3] = '{24'hFFFFFF, 24'd5, 24'd0};
  logic [23:0] ext_b [3] = '{24'd1, 24'hFFFFFF, 24'd3};
  logic [23:0] ext_q [3] = '{24'hFFFFFF, 24'd0, 24'd0};
  logic [23:0] ext_r [3] = '{24'd0, 24'd5, 24'd0};

  initial begin
    int lat, bn, n, hit, miss, seen;
    logic [23:0] ra, rb;
    logic [47:0] recon;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    check_eq("rst_busy", {47'b0, busy}, 48'd0);
    check_eq("rst_done", {47'b0, done}, 48'd0);
    check_eq("rst_q", {24'b0, q}, 48'd0);
    check_eq("rst_r", {24'b0, r}, 48'd0);
    check_eq("rst_dbz", {47'b0, dbz}, 48'd0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // Basic
    run_op(24'd1000, 24'd7, lat, bn);
    check_eq("basic_lat", 48'(lat), 48'd25);
    check_eq("basic_busy_cycles", 48'(bn), 48'd24);
    check_eq("basic_busy_at_done", {47'b0, busy}, 48'd0);
    check_eq("basic_q", {24'b0, q}, 48'd142);
    check_eq("basic_r", {24'b0, r}, 48'd6);
    check_eq("basic_dbz", {47'b0, dbz}, 48'd0);
    step();
    check_eq("basic_done_pulse", {47'b0, done}, 48'd0);

    // Extremes
    for (int i = 0; i < 3; i++) begin
      run_op(ext_a[i], ext_b[i], lat, bn);
      check_eq($sformatf("ext%0d_lat", i), 48'(lat), 48'd25);
      check_eq($sformatf("ext%0d_q", i), {24'b0, q}, {24'b0, ext_q[i]});
      check_eq($sformatf("ext%0d_r", i), {24'b0, r}, {24'b0, ext_r[i]});
      step();
    end

    // Divide by zero, then a normal op clears dbz
    run_op(24'd123, 24'd0, lat, bn);
    check_eq("dbz_lat", 48'(lat), 48'd1);
    check_eq("dbz_busy_cycles", 48'(bn), 48'd0);
    check_eq("dbz_q", {24'b0, q}, 48'hFFFFFF);
    check_eq("dbz_r", {24'b0, r}, 48'd123);
    check_eq("dbz_flag", {47'b0, dbz}, 48'd1);
    step();
    run_op(24'd10, 24'd3, lat, bn);
    check_eq("after_dbz_q", {24'b0, q}, 48'd3);
    check_eq("after_dbz_r", {24'b0, r}, 48'd1);
    check_eq("after_dbz_flag", {47'b0, dbz}, 48'd0);
    step();

    // Re-pulsed start and operand changes mid-run are ignored
    a = 24'd1000; b = 24'd7; start = 1'b1;
    step();
    start = 1'b0; lat = 1;
    repeat (4) begin step(); lat++; end
    start = 1'b1; a = 24'd9; b = 24'd2;
    step(); lat++;
    start = 1'b0; a = 24'h0ABCDE; b = 24'd3;
    while (!done && lat < 40) begin step(); lat++; end
    check_eq("hs_lat", 48'(lat), 48'd25);
    check_eq("hs_q", {24'b0, q}, 48'd142);
    check_eq("hs_r", {24'b0, r}, 48'd6);
    step();
    check_eq("hs_idle_after", {47'b0, busy}, 48'd0);

    // Reset mid-run aborts everything
    a = 24'd1000; b = 24'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", {47'b0, busy}, 48'd0);
    check_eq("midrst_done", {47'b0, done}, 48'd0);
    check_eq("midrst_q", {24'b0, q}, 48'd0);
    check_eq("midrst_r", {24'b0, r}, 48'd0);
    check_eq("midrst_dbz", {47'b0, dbz}, 48'd0);
    step();
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      step();
      if (done) seen = 1;
    end
    check_eq("midrst_no_done", 48'(seen), 48'd0);
    run_op(24'd1000, 24'd7, lat, bn);
    check_eq("postrst_lat", 48'(lat), 48'd25);
    check_eq("postrst_q", {24'b0, q}, 48'd142);
    check_eq("postrst_r", {24'b0, r}, 48'd6);
    step();

    // Start held high: one result every 26 cycles
    a = 24'd100; b = 24'd7; start = 1'b1;
    n = 0;
    while (!done && n < 40) begin step(); n++; end
    check_eq("held_first_lat", 48'(n), 48'd25);
    n = 0;
    do begin step(); n++; end while (!done && n < 40);
    check_eq("held_period", 48'(n), 48'd26);
    check_eq("held_q", {24'b0, q}, 48'd14);
    check_eq("held_r", {24'b0, r}, 48'd2);
    start = 1'b0;
    step();
    step();
    check_eq("held_stop_busy", {47'b0, busy}, 48'd0);

    // Random: a == q*b + r and r < b
    hit = 0; miss = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom) >> $urandom_range(0, 23);
      if (rb == '0) rb = 24'd1;
      run_op(ra, rb, lat, bn);
      recon = 48'(q) * 48'(rb) + 48'(r);
      if (done && r < rb && recon == 48'(ra) && !dbz) hit++;
      else miss++;
      step();
    end
    $display("random: hit=%0d miss=%0d", hit, miss);
    check_eq("random_miss", 48'(miss), 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
